// File: rtl/ks_pkg.sv
// Shared types and arithmetic helpers for the polyphonic Karplus-Strong engine.
package ks_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_WR,
    ST_MIX
  } ks_state_e;

  function automatic int unsigned ks_width(input int unsigned dw, input int unsigned ew,
                                           input int unsigned fb);
    return dw + ew + fb;
  endfunction

  function automatic int unsigned ks_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ks_noise_pos(input int unsigned dw, input int unsigned fb);
    return ((1 << (dw - 1)) - 1) << fb;
  endfunction

  function automatic int ks_noise_neg(input int unsigned dw, input int unsigned fb);
    return -(1 << (dw - 1 + fb));
  endfunction

  // Clamp a fixed-point value to the range of a signed dw-bit integer part.
  function automatic int ks_sat(input int val, input int unsigned dw, input int unsigned fb);
    int hi;
    int lo;
    hi = (1 << (dw - 1 + fb)) - 1;
    lo = -(1 << (dw - 1 + fb));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/ks_delay_ram.sv
// Single-port delay memory shared by all voices; synchronous read, no reset.
module ks_delay_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ks_poly_string.sv
// Time-multiplexed Karplus-Strong voices sharing one filter datapath and one delay RAM;
// each audio tick walks every voice through RD/CALC/WR and then publishes the mix.
module ks_poly_string
  import ks_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned MAX_LENGTH = 256,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EXTN_BITS  = 4,
  parameter int unsigned FRAC_BITS  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               sample_en_i,
  input  logic                               freeze_i,
  input  logic                               round_en_i,
  input  logic [NUM_VOICES-1:0]              pluck_i,
  input  logic [NUM_VOICES-1:0]              drum_string_ni,
  input  logic [NUM_VOICES*DATA_WIDTH-1:0]   period_i,
  input  logic [1:0]                         prbs_data_i,
  output logic [NUM_VOICES*DATA_WIDTH-1:0]   voice_sample_o,
  output logic signed [DATA_WIDTH-1:0]       mix_o,
  output logic                               mix_valid_o,
  output logic                               busy_o,
  output logic                               overrun_o
);

  localparam int unsigned W   = ks_width(DATA_WIDTH, EXTN_BITS, FRAC_BITS);
  localparam int unsigned VB  = ks_log2(NUM_VOICES);
  localparam int unsigned AW  = ks_log2(MAX_LENGTH);
  localparam int unsigned RAW = VB + AW;
  localparam int unsigned MW  = DATA_WIDTH + VB;
  localparam logic signed [W-1:0] NOISE_P  = W'(ks_noise_pos(DATA_WIDTH, FRAC_BITS));
  localparam logic signed [W-1:0] NOISE_N  = W'(ks_noise_neg(DATA_WIDTH, FRAC_BITS));
  localparam logic signed [W-1:0] RND_HALF = W'(1 << (FRAC_BITS - 1));

  ks_state_e state;
  logic [VB-1:0]  v;
  logic [RAW-1:0] clr_addr;

  logic [AW-1:0]                  wptr      [NUM_VOICES];
  logic signed [DATA_WIDTH-1:0]   prev      [NUM_VOICES];
  logic [AW:0]                    burst_cnt [NUM_VOICES];
  logic signed [DATA_WIDTH-1:0]   sample    [NUM_VOICES];
  logic [NUM_VOICES-1:0]          pend, pend_clr;
  logic [NUM_VOICES-1:0]          pluck_s1, pluck_s2, pluck_s3;

  logic signed [DATA_WIDTH-1:0]   xp_q, new_q;

  logic                  ram_we;
  logic [RAW-1:0]        ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  logic [DATA_WIDTH-1:0]        per_raw;
  logic [AW:0]                  p_len;
  logic [AW-1:0]                rd_off;
  logic signed [W-1:0]          xp_ext, xp1_ext, avg, noise, sum_w;
  int                           sum_sat;
  logic signed [DATA_WIDTH-1:0] calc_sample;
  logic signed [MW-1:0]         mix_acc, mix_shift;

  ks_delay_ram #(
    .DEPTH(NUM_VOICES * MAX_LENGTH),
    .AW   (RAW),
    .DW   (DATA_WIDTH)
  ) u_ram (
    .clk_i(clk_i),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    per_raw = period_i[32'(v)*DATA_WIDTH +: DATA_WIDTH];
    if (32'(per_raw) < 32'd2)               p_len = (AW+1)'(2);
    else if (32'(per_raw) > MAX_LENGTH)     p_len = (AW+1)'(MAX_LENGTH);
    else                                    p_len = (AW+1)'(per_raw);
    // A period of exactly MAX_LENGTH truncates to 0 here and reads the word about to be overwritten.
    rd_off = wptr[v] - p_len[AW-1:0];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = clr_addr;
    ram_wdata = '0;
    unique case (state)
      ST_CLEAR: ram_we = 1'b1;
      ST_RD:    ram_addr = {v, rd_off};
      ST_WR: begin
        ram_we    = 1'b1;
        ram_addr  = {v, wptr[v]};
        ram_wdata = new_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    xp_ext  = W'($signed(ram_rdata));
    xp1_ext = W'(prev[v]);
    avg     = ((xp_ext + xp1_ext) <<< FRAC_BITS) >>> 1;
    if (drum_string_ni[v] && !prbs_data_i[0]) avg = -avg;
    noise = '0;
    if (burst_cnt[v] != '0) begin
      if (prbs_data_i == 2'b11)      noise = NOISE_P;
      else if (prbs_data_i == 2'b10) noise = NOISE_N;
    end
    sum_w       = avg + noise + (round_en_i ? RND_HALF : '0);
    sum_sat     = ks_sat(int'(sum_w), DATA_WIDTH, FRAC_BITS);
    calc_sample = DATA_WIDTH'(sum_sat >>> FRAC_BITS);
  end

  // Mix is formed during the last WR so it can be registered as mix_valid_o rises.
  always_comb begin
    mix_acc = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      mix_acc = mix_acc + MW'((VB'(i) == v) ? new_q : sample[i]);
    end
    mix_shift = mix_acc >>> VB;
  end

  always_comb begin
    pend_clr = '0;
    if (state == ST_RD && pend[v]) pend_clr[v] = 1'b1;
  end

  always_comb begin
    voice_sample_o = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_sample_o[i*DATA_WIDTH +: DATA_WIDTH] = sample[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_CLEAR;
      v           <= '0;
      clr_addr    <= '0;
      xp_q        <= '0;
      new_q       <= '0;
      pluck_s1    <= '0;
      pluck_s2    <= '0;
      pluck_s3    <= '0;
      pend        <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        wptr[i]      <= '0;
        prev[i]      <= '0;
        burst_cnt[i] <= '0;
        sample[i]    <= '0;
      end
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      pluck_s1    <= pluck_i;
      pluck_s2    <= pluck_s1;
      pluck_s3    <= pluck_s2;
      pend        <= (pend & ~pend_clr) | (pluck_s2 & ~pluck_s3);
      mix_valid_o <= 1'b0;
      if (sample_en_i && busy_o) overrun_o <= 1'b1;

      unique case (state)
        ST_CLEAR: begin
          busy_o   <= 1'b1;
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) state <= ST_IDLE;
        end
        ST_IDLE: begin
          // busy_o still high here for one cycle after CLEAR, so that tick counts as overrun.
          if (sample_en_i && !freeze_i && !busy_o) begin
            busy_o <= 1'b1;
            v      <= '0;
            state  <= ST_RD;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ST_RD: begin
          if (pend[v]) burst_cnt[v] <= p_len;
          state <= ST_CALC;
        end
        ST_CALC: begin
          xp_q  <= $signed(ram_rdata);
          new_q <= calc_sample;
          state <= ST_WR;
        end
        ST_WR: begin
          wptr[v]   <= wptr[v] + 1'b1;
          prev[v]   <= xp_q;
          sample[v] <= new_q;
          if (burst_cnt[v] != '0) burst_cnt[v] <= burst_cnt[v] - 1'b1;
          if (v == VB'(NUM_VOICES - 1)) begin
            mix_o       <= DATA_WIDTH'(mix_shift);
            mix_valid_o <= 1'b1;
            state       <= ST_MIX;
          end else begin
            v     <= v + 1'b1;
            state <= ST_RD;
          end
        end
        ST_MIX: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_poly_string.sv
// Bench for ks_poly_string: directed steps plus randomized ticks against a behavioural string model.
module tb_ks_poly_string;

  localparam int NV = 4;
  localparam int ML = 256;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en = 1'b0;
  logic freeze = 1'b0;
  logic round_en = 1'b0;
  logic [NV-1:0] pluck = '0;
  logic [NV-1:0] drum = '0;
  logic [NV*DW-1:0] period = '0;
  logic [1:0] prbs = 2'b00;
  logic [NV*DW-1:0] vs;
  logic signed [DW-1:0] mix;
  logic mix_valid, busy, overrun;

  int total = 0;
  int bad = 0;

  int m_mem [NV][ML];
  int m_wptr [NV];
  int m_prev [NV];
  int m_burst [NV];
  int m_sample [NV];
  bit m_pend [NV];

  always #5 clk = ~clk;

  ks_poly_string #(
    .NUM_VOICES(NV),
    .MAX_LENGTH(ML),
    .DATA_WIDTH(DW),
    .EXTN_BITS (4),
    .FRAC_BITS (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sample_en_i   (sample_en),
    .freeze_i      (freeze),
    .round_en_i    (round_en),
    .pluck_i       (pluck),
    .drum_string_ni(drum),
    .period_i      (period),
    .prbs_data_i   (prbs),
    .voice_sample_o(vs),
    .mix_o         (mix),
    .mix_valid_o   (mix_valid),
    .busy_o        (busy),
    .overrun_o     (overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_sample(input int v);
    logic [DW-1:0] s;
    s = vs[v*DW +: DW];
    return int'($signed(s));
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      for (int a = 0; a < ML; a++) m_mem[v][a] = 0;
      m_wptr[v] = 0; m_prev[v] = 0; m_burst[v] = 0; m_sample[v] = 0; m_pend[v] = 0;
    end
  endtask

  task automatic set_period(input int v, input int p);
    period[v*DW +: DW] = 8'(p);
  endtask

  // One audio tick of the reference: read the sample P behind, low-pass with the previous read,
  // optional drum sign flip, burst noise, rounding, saturation, then write back.
  task automatic model_tick();
    int p, xp, avg, noise, sum, s;
    for (int v = 0; v < NV; v++) begin
      p = int'(period[v*DW +: DW]);
      if (p < 2) p = 2;
      if (p > ML) p = ML;
      if (m_pend[v]) begin
        m_burst[v] = p;
        m_pend[v] = 0;
      end
      xp = m_mem[v][((m_wptr[v] - p) % ML + ML) % ML];
      avg = (xp + m_prev[v]) * 8;
      if (drum[v] && prbs[0] == 1'b0) avg = -avg;
      noise = 0;
      if (m_burst[v] > 0) begin
        if (prbs == 2'b11) noise = 127 * 16;
        else if (prbs == 2'b10) noise = -128 * 16;
      end
      sum = avg + noise + (round_en ? 8 : 0);
      s = sum >>> 4;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      m_mem[v][m_wptr[v]] = s;
      m_wptr[v] = (m_wptr[v] + 1) % ML;
      m_prev[v] = xp;
      m_sample[v] = s;
      if (m_burst[v] > 0) m_burst[v]--;
    end
  endtask

  function automatic int model_mix();
    int acc;
    acc = 0;
    for (int v = 0; v < NV; v++) acc += m_sample[v];
    return acc >>> 2;
  endfunction

  task automatic do_tick(input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    sample_en = 1'b1;
    model_tick();
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      sample_en = 1'b0;
      cyc++;
      if (cyc == 1) check({tag, " busy_start"}, int'(busy), 1);
      if (mix_valid) seen = 1'b1;
    end
    check({tag, " latency"}, cyc, 13);
    check({tag, " mix"}, int'(mix), model_mix());
    for (int v = 0; v < NV; v++) check($sformatf("%s voice%0d", tag, v), dut_sample(v), m_sample[v]);
    @(negedge clk);
    check({tag, " valid_pulse"}, int'(mix_valid), 0);
    check({tag, " busy_end"}, int'(busy), 0);
  endtask

  task automatic do_pluck(input int v);
    @(negedge clk);
    pluck[v] = 1'b1;
    repeat (3) @(negedge clk);
    pluck[v] = 1'b0;
    repeat (4) @(negedge clk);
    m_pend[v] = 1'b1;
  endtask

  task automatic wait_clear(input string tag, input bit inject);
    int n;
    bit saw_valid;
    n = 0;
    saw_valid = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (mix_valid) saw_valid = 1'b1;
      if (busy) n++;
      else if (n > 0) break;
      sample_en = (inject && g == 10);
    end
    sample_en = 1'b0;
    check({tag, " busy_len"}, n, NV * ML);
    check({tag, " no_valid"}, int'(saw_valid), 0);
  endtask

  initial begin
    int s3;
    bit saw_valid, saw_busy;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst voices", int'(vs), 0);
    check("rst mix", int'(mix), 0);
    check("rst valid", int'(mix_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    rst_n = 1'b1;
    wait_clear("clear", 1'b1);
    check("overrun sticky", int'(overrun), 1);

    // Idle engine: silence, fixed latency
    for (int t = 0; t < 3; t++) begin
      set_period(t, $urandom_range(0, 255));
      do_tick("silent");
      check("silent mix zero", int'(mix), 0);
      repeat (6) @(negedge clk);
    end

    // Voice 0, P=4, full-scale noise burst
    for (int v = 0; v < NV; v++) set_period(v, 0);
    set_period(0, 4);
    prbs = 2'b11;
    do_pluck(0);
    for (int t = 0; t < 8; t++) begin
      do_tick("p4");
      if (t < 4) begin
        check("p4 burst sample", dut_sample(0), 127);
        check("p4 burst mix", int'(mix), 31);
      end
    end

    // Drum voice saturating at -128: negative avg plus negative noise
    drum[3] = 1'b1;
    set_period(3, 2);
    prbs = 2'b11;
    do_pluck(3);
    do_tick("drum1");
    do_tick("drum2");
    do_pluck(3);
    prbs = 2'b10;
    do_tick("drum3");
    s3 = dut_sample(3);
    check("drum sat", s3, -128);

    // Randomized run: P=0 on voice 1, P=255 on voice 2, wptr wraps
    set_period(1, 0);
    set_period(2, 255);
    set_period(3, $urandom_range(2, 40));
    do_pluck(1);
    do_pluck(2);
    for (int t = 0; t < 300; t++) begin
      prbs = 2'($urandom_range(0, 3));
      round_en = 1'($urandom_range(0, 1));
      drum = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) do_pluck($urandom_range(0, NV - 1));
      do_tick("rand");
    end

    // Freeze: ticks ignored, state held
    freeze = 1'b1;
    saw_valid = 1'b0;
    saw_busy = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      for (int c = 0; c < 18; c++) begin
        @(negedge clk);
        if (mix_valid) saw_valid = 1'b1;
        if (busy) saw_busy = 1'b1;
      end
    end
    check("freeze no valid", int'(saw_valid), 0);
    check("freeze no busy", int'(saw_busy), 0);
    for (int v = 0; v < NV; v++) check($sformatf("freeze hold%0d", v), dut_sample(v), m_sample[v]);
    freeze = 1'b0;
    do_tick("post_freeze");

    // Reset asserted during CALC of voice 0
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("calc_rst voices", int'(vs), 0);
    check("calc_rst mix", int'(mix), 0);
    check("calc_rst busy", int'(busy), 0);
    check("calc_rst overrun", int'(overrun), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_clear("reclear", 1'b0);
    check("reclear overrun", int'(overrun), 0);
    drum = '0;
    prbs = 2'b11;
    round_en = 1'b1;
    set_period(2, 3);
    do_pluck(2);
    for (int t = 0; t < 5; t++) do_tick("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
